// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding definitions for the instruction encoder/loader.
// Provides the opcode constants, the descriptor format enum, the loader FSM
// state enum and the packed descriptor payload consumed by rv_inst_pack.
package rv_isa_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        FMT_R     = 2'd0,
        FMT_I     = 2'd1,
        FMT_LOAD  = 2'd2,
        FMT_STORE = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Decoded instruction descriptor as presented on the input stream
    typedef struct packed {
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm;
    } inst_desc_t;

endpackage

// File: rtl/rv_inst_pack.sv
// Combinational RV32I encoder: descriptor -> 32-bit machine word.
// Ports:
//   desc_i     decoded instruction descriptor (format + fields)
//   word_c_o   encoded instruction word (combinational)
module rv_inst_pack
    import rv_isa_pkg::*;
(
    input  inst_desc_t          desc_i,
    output logic [WORD_W-1:0]   word_c_o
);

    // Fields a format does not use are simply left out of its concatenation
    always_comb begin
        word_c_o = '0;
        case (desc_i.fmt)
            FMT_R:     word_c_o = {desc_i.funct7, desc_i.rs2, desc_i.rs1,
                                   desc_i.funct3, desc_i.rd, OP_R};
            FMT_I:     word_c_o = {desc_i.imm, desc_i.rs1, desc_i.funct3,
                                   desc_i.rd, OP_I};
            FMT_LOAD:  word_c_o = {desc_i.imm, desc_i.rs1, desc_i.funct3,
                                   desc_i.rd, OP_LOAD};
            FMT_STORE: word_c_o = {desc_i.imm[11:5], desc_i.rs2, desc_i.rs1,
                                   desc_i.funct3, desc_i.imm[4:0], OP_STORE};
            default:   word_c_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// Sequential RV32I encoder and program loader. Accepts descriptors over a
// valid/ready stream, encodes each one and writes it to consecutive
// instruction-memory word addresses starting at BASE_ADDR.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               open a load session (IDLE only)
//   in_valid/in_ready   descriptor handshake; in_ready is combinational
//   in_fmt..in_last     descriptor fields, in_last closes the session
//   mem_we/mem_ready    write request held until accepted by memory
//   mem_addr/mem_wdata  word address and encoded word of the pending write
//   busy, done          session active / one-cycle completion pulse
//   count, err_full     descriptors accepted, sticky overflow flag
module rv_inst_encoder
    import rv_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_fmt,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_funct3,
    input  logic [6:0]          in_funct7,
    input  logic [11:0]         in_imm,
    input  logic                in_last,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     count,
    output logic                err_full
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    inst_desc_t          desc;
    logic [WORD_W-1:0]   enc_word;
    logic                accept;
    logic                wr_done;

    // Pack the stream fields into the encoder payload
    always_comb begin
        desc.fmt    = fmt_e'(in_fmt);
        desc.rd     = in_rd;
        desc.rs1    = in_rs1;
        desc.rs2    = in_rs2;
        desc.funct3 = in_funct3;
        desc.funct7 = in_funct7;
        desc.imm    = in_imm;
    end

    rv_inst_pack u_pack (
        .desc_i   (desc),
        .word_c_o (enc_word)
    );

    // Ready when the output register frees up this cycle and room remains
    assign in_ready = (state_q == ST_RUN) && (!we_q || mem_ready) &&
                      (count_q < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign wr_done  = we_q && mem_ready;

    // Next-state logic: a completing write and a new accept may coincide
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    err_d   = 1'b0;
                    ptr_d   = ADDR_W'(BASE_ADDR);
                end
            end
            ST_RUN: begin
                if (wr_done) begin
                    we_d = 1'b0;
                end
                if (accept) begin
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                    addr_d  = ptr_q;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = count_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end else if (count_q + CNT_W'(1) == CNT_W'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_done) begin
                    we_d = 1'b0;
                end
                if (!we_q || mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= ADDR_W'(BASE_ADDR);
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err_full  = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Scoreboard bench for rv_inst_encoder. Three instances share the descriptor
// stream and mem_ready: dut0 default parameters, dut1 DEPTH=4 (overflow),
// dut2 ADDR_W=2/BASE_ADDR=3/DEPTH=3 (address wrap). Only the started
// instance may accept; any write not predicted is flagged.
module tb_rv_inst_encoder;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = 3'b000;
    logic        in_valid = 1'b0;
    logic [1:0]  in_fmt = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [11:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_ready = 1'b0;

    logic [2:0]  rdy, we, busy, done, err;
    logic [7:0]  addr0, addr1;
    logic [1:0]  addr2;
    logic [31:0] wd0, wd1, wd2;
    logic [8:0]  cnt0, cnt1;
    logic [2:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr[3];
    int mask[3] = '{255, 255, 3};
    int base[3] = '{0, 0, 3};
    int done_cnt[3] = '{0, 0, 0};
    int d0[3] = '{0, 0, 0};
    logic [63:0] q0[$], q1[$], q2[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    rv_inst_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(we[0]), .mem_ready(mem_ready), .mem_addr(addr0), .mem_wdata(wd0),
        .busy(busy[0]), .done(done[0]), .count(cnt0), .err_full(err[0]));

    rv_inst_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(we[1]), .mem_ready(mem_ready), .mem_addr(addr1), .mem_wdata(wd1),
        .busy(busy[1]), .done(done[1]), .count(cnt1), .err_full(err[1]));

    rv_inst_encoder #(.ADDR_W(2), .DEPTH(3), .BASE_ADDR(3)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(we[2]), .mem_ready(mem_ready), .mem_addr(addr2), .mem_wdata(wd2),
        .busy(busy[2]), .done(done[2]), .count(cnt2), .err_full(err[2]));

    function automatic logic [31:0] f_addr(input int k);
        case (k)
            0:       return 32'(addr0);
            1:       return 32'(addr1);
            default: return 32'(addr2);
        endcase
    endfunction

    function automatic logic [31:0] f_wd(input int k);
        case (k)
            0:       return wd0;
            1:       return wd1;
            default: return wd2;
        endcase
    endfunction

    function automatic logic [31:0] f_cnt(input int k);
        case (k)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [31:0] w);
        logic [63:0] e;
        e = {32'(ptr[k]), w};
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        ptr[k] = (ptr[k] + 1) & mask[k];
    endtask

    task automatic check_write(input int k);
        logic [63:0] e;
        bit have;
        have = (qsize(k) > 0);
        if (have) begin
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("wr_addr%0d", k), f_addr(k), e[63:32]);
            chk($sformatf("wr_data%0d", k), f_wd(k), e[31:0]);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_write%0d: got addr 0x%08h data 0x%08h expected no write",
                     k, f_addr(k), f_wd(k));
        end
    endtask

    // Monitor: a write completes at the coming edge when mem_we && mem_ready
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (done[k]) done_cnt[k]++;
                if (we[k] && mem_ready) check_write(k);
            end
        end
    end

    task automatic start_sess(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        ptr[k]   = base[k];
        d0[k]    = done_cnt[k];
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic send(input int k, input int vi, input logic last, input bit exp_acc,
                        input logic mr, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        @(negedge clk);
        in_fmt    = vecs[vi].fmt;
        in_rd     = vecs[vi].rd;
        in_rs1    = vecs[vi].rs1;
        in_rs2    = vecs[vi].rs2;
        in_funct3 = vecs[vi].f3;
        in_funct7 = vecs[vi].f7;
        in_imm    = vecs[vi].imm;
        in_last   = last;
        in_valid  = 1'b1;
        mem_ready = mr;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rdy[k]) begin
                push(k, vecs[vi].word);
                acc = 1'b1;
                @(posedge clk);
                break;
            end
            waited++;
            @(negedge clk);
        end
        chk(exp_acc ? "accept" : "no_accept", 32'(acc), 32'(exp_acc));
    endtask

    task automatic finish_sess(input int k, input int cnt, input logic er);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!busy[k]) break;
            @(negedge clk);
        end
        chk("session_end", 32'(busy[k]), 32'd0);
        chk("done_pulses", 32'(done_cnt[k] - d0[k]), 32'd1);
        chk("count", f_cnt(k), 32'(cnt));
        chk("err_full", 32'(err[k]), 32'(er));
        chk("drained", 32'(qsize(k)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Unused fields carry junk so that leaking them into the word shows up
        vecs[0] = '{2'd0, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 12'hABC, 32'h002081B3};
        vecs[1] = '{2'd1, 5'd5, 5'd0, 5'd31, 3'd0, 7'h7F, 12'hFFF, 32'hFFF00293};
        vecs[2] = '{2'd2, 5'd6, 5'd1, 5'd5,  3'd2, 7'h55, 12'h008, 32'h0080A303};
        vecs[3] = '{2'd3, 5'd9, 5'd2, 5'd6,  3'd2, 7'h03, 12'h00C, 32'h00612623};

        // Reset state of every instance
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_we",    32'(we[k]),   32'd0);
            chk("rst_done",  32'(done[k]), 32'd0);
            chk("rst_busy",  32'(busy[k]), 32'd0);
            chk("rst_ready", 32'(rdy[k]),  32'd0);
            chk("rst_err",   32'(err[k]),  32'd0);
            chk("rst_count", f_cnt(k),     32'd0);
            chk("rst_addr",  f_addr(k),    32'(base[k]));
            chk("rst_wdata", f_wd(k),      32'd0);
        end
        rst = 1'b0;

        // Valid without start is never accepted
        in_valid  = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("nostart_ready", 32'(rdy[0]), 32'd0);
            chk("nostart_we",    32'(we[0]),  32'd0);
        end
        in_valid = 1'b0;

        // Encoding of each format, addresses 0..3
        start_sess(0);
        for (int i = 0; i < 4; i++) send(0, i, i == 3, 1'b1, 1'b1, w);
        finish_sess(0, 4, 1'b0);

        // Back-pressure: first write stalled for three cycles
        start_sess(0);
        send(0, 0, 1'b0, 1'b1, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("bp_we",    32'(we[0]),  32'd1);
            chk("bp_addr",  f_addr(0),   32'd0);
            chk("bp_wdata", f_wd(0),     vecs[0].word);
            chk("bp_ready", 32'(rdy[0]), 32'd0);
        end
        for (int i = 1; i < 8; i++) begin
            send(0, i % 4, i == 7, 1'b1, 1'b1, w);
            chk("b2b_stall", 32'(w), 32'd0);
        end
        finish_sess(0, 8, 1'b0);

        // Overflow: DEPTH=4, six descriptors without last
        start_sess(1);
        for (int i = 0; i < 6; i++) send(1, i % 4, 1'b0, i < 4, 1'b1, w);
        finish_sess(1, 4, 1'b1);

        // Abort: reset with a stalled write pending
        start_sess(0);
        send(0, 2, 1'b0, 1'b1, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("abort_we_before", 32'(we[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_we",   32'(we[0]),   32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_dropped", 32'(q0.size()), 32'd1);
        q0.delete();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt[0] - d0[0]), 32'd0);
        start_sess(0);
        send(0, 1, 1'b1, 1'b1, 1'b1, w);
        finish_sess(0, 1, 1'b0);

        // Wrap: ADDR_W=2, BASE_ADDR=3 -> addresses 3, 0, 1
        start_sess(2);
        for (int i = 0; i < 3; i++) send(2, i, i == 2, 1'b1, 1'b1, w);
        finish_sess(2, 3, 1'b0);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk("final_empty", 32'(qsize(k)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
